// File: rtl/bcd_seven_seg_driver_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
package bcd_seven_seg_driver_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Active-low anode and cathode idle values (everything dark).
    localparam logic [7:0] ANODE_OFF   = 8'hFF;
    localparam logic [6:0] CATHODE_OFF = 7'h7F;

    // Active-low segment patterns, bit order g..a (bit 6 = g, bit 0 = a).
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // One-cold anode pattern enabling a single digit.
    function automatic logic [7:0] anode_select(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/bin2bcd_comb.sv
// Combinational 32-bit binary to 10-digit BCD converter (shift-add-3).
module bin2bcd_comb (
    input  logic [31:0] bin,
    output logic [39:0] bcd
);

    // Unrolled double-dabble: adjust every digit, then shift in the next bit.
    always_comb begin
        logic [39:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            for (int d = 0; d < 10; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[38:0], bin[31-i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment pattern (g..a).
module seg7_decode
    import bcd_seven_seg_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Full 16-entry table; A-F kept so the decoder is a complete hex decoder.
    always_comb begin
        seg = CATHODE_OFF;
        case (digit)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = CATHODE_OFF;
        endcase
    end

endmodule

// File: rtl/bcd_seven_seg_driver.sv
// 8-digit multiplexed common-anode display driver: binary -> BCD -> scanned segments.
module bcd_seven_seg_driver
    import bcd_seven_seg_driver_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] thirtytwo_bit_number,
    output logic [6:0]  cathode,
    output logic [7:0]  anode,
    output logic [31:0] bcd,
    output logic        overflow,
    output logic        ms_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_TICK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_TICK - 1);

    logic [39:0]      bcd_full;
    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [3:0]       scan_digit;
    logic [6:0]       scan_seg;
    logic [7:0]       anode_d;
    logic [6:0]       cathode_d;

    bin2bcd_comb u_bin2bcd (
        .bin (thirtytwo_bit_number),
        .bcd (bcd_full)
    );

    // Register the low 8 digits; anything in the top two digits means > 99,999,999.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            bcd      <= bcd_full[31:0];
            overflow <= |bcd_full[39:32];
        end
    end

    // Scan-rate divider next state: free-running 0..CLKS_PER_TICK-1.
    always_comb begin
        ms_tick   = (div_cnt_q == CNT_MAX);
        div_cnt_d = ms_tick ? '0 : div_cnt_q + 1'b1;
    end

    // Divider state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign scan_digit = bcd[{state_q, 2'b00} +: 4];

    seg7_decode u_seg7 (
        .digit (scan_digit),
        .seg   (scan_seg)
    );

    // Scan next state: on a tick, light the indexed digit and advance (wraps 7 -> 0).
    always_comb begin
        state_d   = state_q;
        anode_d   = anode;
        cathode_d = cathode;
        if (ms_tick) begin
            anode_d   = anode_select(state_q);
            cathode_d = scan_seg;
            state_d   = state_q + 3'd1;
        end
    end

    // Anode and cathode both registered so they switch together without glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            anode   <= ANODE_OFF;
            cathode <= CATHODE_OFF;
        end else begin
            state_q <= state_d;
            anode   <= anode_d;
            cathode <= cathode_d;
        end
    end

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// Scoreboard bench for bcd_seven_seg_driver with a decimal-arithmetic reference model.
module tb_bcd_seven_seg_driver;

    localparam int unsigned CPT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] thirtytwo_bit_number = '0;
    logic [6:0]  cathode;
    logic [7:0]  anode;
    logic [31:0] bcd;
    logic        overflow;
    logic        ms_tick;

    int checks = 0;
    int errors = 0;

    bcd_seven_seg_driver #(.CLKS_PER_TICK(CPT)) dut (
        .clock                (clock),
        .reset                (reset),
        .thirtytwo_bit_number (thirtytwo_bit_number),
        .cathode              (cathode),
        .anode                (anode),
        .bcd                  (bcd),
        .overflow             (overflow),
        .ms_tick              (ms_tick)
    );

    always #5 clock = ~clock;

    // Segment patterns written straight from the g..a table.
    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  an;
        logic [6:0]  ca;
        logic        tick;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned dec_digit(input int unsigned v, input int k);
        int unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'(dec_digit(v, k));
        return r;
    endfunction

    // Reference model: per edge, predict all outputs from decimal arithmetic.
    int unsigned m_cnt = 0;
    int unsigned m_digit = 0;
    int unsigned m_num = 0;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_ca = 7'h7F;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_digit = 0; m_num = 0; m_an = 8'hFF; m_ca = 7'h7F;
            sb.delete();
        end else begin
            exp_t e;
            if (m_cnt == CPT - 1) begin
                m_an    = 8'hFF;
                m_an[m_digit] = 1'b0;
                m_ca    = seg_ref[dec_digit(m_num % 100000000, m_digit)];
                m_digit = (m_digit + 1) % 8;
            end
            m_cnt = (m_cnt + 1) % CPT;
            m_num = thirtytwo_bit_number;
            e.bcd  = to_bcd(m_num % 100000000);
            e.ovf  = (m_num > 99999999);
            e.an   = m_an;
            e.ca   = m_ca;
            e.tick = (m_cnt == CPT - 1);
            sb.push_back(e);
        end
    end

    // Monitor: compare outputs a little after each edge against the queued prediction.
    always begin
        @(posedge clock);
        #3;
        if (!reset && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("bcd", 64'(bcd), 64'(e.bcd));
            check("overflow", 64'(overflow), 64'(e.ovf));
            check("anode", 64'(anode), 64'(e.an));
            check("cathode", 64'(cathode), 64'(e.ca));
            check("ms_tick", 64'(ms_tick), 64'(e.tick));
        end
    end

    task automatic hold(input logic [31:0] v, input int n);
        @(posedge clock); #1;
        thirtytwo_bit_number = v;
        repeat (n - 1) @(posedge clock);
    endtask

    initial begin
        logic [31:0] vals [5] = '{32'd12345678, 32'd0, 32'hFFFFFFFF, 32'd99999999, 32'd100000000};
        bit found;

        repeat (2) @(posedge clock);
        #2;
        check("reset_anode", 64'(anode), 64'hFF);
        check("reset_cathode", 64'(cathode), 64'h7F);
        check("reset_bcd", 64'(bcd), 64'h0);
        check("reset_overflow", 64'(overflow), 64'h0);
        check("reset_ms_tick", 64'(ms_tick), 64'h0);

        @(posedge clock); #1;
        reset = 1'b0;

        // Directed values, each held for more than one full refresh.
        foreach (vals[i]) hold(vals[i], 40);

        // Randomized values: mostly held a while, sometimes changed every cycle.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99999999);
                2: v = 32'd99999999 + $urandom_range(0, 2) - 1;
                default: v = $urandom_range(0, 9999);
            endcase
            hold(v, $urandom_range(1, 12));
        end

        // Reset while digit 5 is lit; outputs must clear without a clock edge.
        hold(32'd87654321, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock); #1;
            if (anode == 8'hDF) found = 1;
        end
        check("digit5_seen", 64'(found), 64'h1);
        #3;
        reset = 1'b1;
        #1;
        check("async_anode", 64'(anode), 64'hFF);
        check("async_cathode", 64'(cathode), 64'h7F);
        check("async_bcd", 64'(bcd), 64'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock); #1;
            if (anode != 8'hFF) found = 1;
        end
        check("restart_seen", 64'(found), 64'h1);
        check("restart_digit0", 64'(anode), 64'hFE);

        hold(32'd4096, 40);
        repeat (3) @(posedge clock);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
